// File: rtl/conversor_c2_sm.sv
// Bit-serial two's-complement to sign-magnitude converter.
// Scans the operand LSB-first: bits are copied until the first one, then inverted if negative.
module conversor_c2_sm #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] entrada,
    output logic             busy,
    output logic             done,
    output logic             sinal,
    output logic [WIDTH-1:0] magnitude,
    output logic             extremo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] ULTIMO = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SO_MSB = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic {
        OCIOSO,
        CONVERTE
    } estado_t;

    estado_t          estado;
    logic [WIDTH-1:0] op;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             sinal_int;
    logic             visto_um;

    logic             out_bit;
    logic [WIDTH-1:0] res_prox;
    logic             extremo_prox;

    // Inversion only kicks in for negatives, strictly after the first one has passed.
    always_comb begin
        out_bit      = op[0] ^ (sinal_int & visto_um);
        res_prox     = {out_bit, res[WIDTH-1:1]};
        extremo_prox = sinal_int & (res_prox == SO_MSB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= OCIOSO;
            op        <= '0;
            res       <= '0;
            cnt       <= '0;
            sinal_int <= 1'b0;
            visto_um  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sinal     <= 1'b0;
            magnitude <= '0;
            extremo   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (start) begin
                        op        <= entrada;
                        sinal_int <= entrada[WIDTH-1];
                        visto_um  <= 1'b0;
                        cnt       <= '0;
                        res       <= '0;
                        busy      <= 1'b1;
                        estado    <= CONVERTE;
                    end
                end
                CONVERTE: begin
                    op       <= {1'b0, op[WIDTH-1:1]};
                    visto_um <= visto_um | op[0];
                    res      <= res_prox;
                    if (cnt == ULTIMO) begin
                        sinal     <= sinal_int;
                        magnitude <= res_prox;
                        extremo   <= extremo_prox;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        estado    <= OCIOSO;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    estado <= OCIOSO;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
